// File: rtl/seven_seg_scan_driver.sv
// rtl/seven_seg_scan_driver.sv - 4-digit multiplexed seven-segment scan driver with frame-atomic update
// Optional feature macro: SEG_LEADING_ZERO_BLANK_EN (leading-zero suppression on enabled digits)
module seven_seg_scan_driver #(
    parameter int unsigned REFRESH_DIV    = 100000,
    parameter int unsigned BLANK_CYC      = 1000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic [15:0] disp_value,
    input  logic [3:0]  disp_dp,
    input  logic [3:0]  disp_en,
    input  logic        disp_load,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic [1:0]  active_digit,
    output logic        frame_sync
);

    localparam int unsigned CW      = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    typedef enum logic {
        S_BLANK = 1'b0,
        S_ON    = 1'b1
    } slot_e;

    // Slot timing
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    digit_q, digit_d;
    logic          frame_edge_q, frame_edge_d;

    // Pending (staging) and active (displayed) register sets
    logic [15:0]   pend_val_q, pend_val_d;
    logic [3:0]    pend_dp_q, pend_dp_d;
    logic [3:0]    pend_en_q, pend_en_d;
    logic          pend_valid_q, pend_valid_d;
    logic [15:0]   act_val_q, act_val_d;
    logic [3:0]    act_dp_q, act_dp_d;
    logic [3:0]    act_en_q, act_en_d;

    // Registered pin drivers
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    an_q, an_d;
    logic [1:0]    active_digit_q, active_digit_d;
    logic          frame_sync_q, frame_sync_d;

    slot_e         slot_s;
    logic          slot_end;
    logic          frame_end;
    logic [3:0]    nibble;
    logic [3:0]    lz_blank;

    function automatic logic [6:0] hex_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign slot_end  = (cnt_q == CNT_MAX);
    assign frame_end = slot_end && (digit_q == 2'd3);
    assign nibble    = act_val_q[{digit_q, 2'b00} +: 4];

    // Slot counter, digit advance and the frame-boundary commit of pending into active
    always_comb begin
        cnt_d        = slot_end ? '0 : cnt_q + 1'b1;
        digit_d      = slot_end ? digit_q + 2'd1 : digit_q;
        frame_edge_d = frame_end;
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_en_d    = pend_en_q;
        pend_valid_d = pend_valid_q;
        act_val_d    = act_val_q;
        act_dp_d     = act_dp_q;
        act_en_d     = act_en_q;
        if (frame_end) begin
            // A load landing on the boundary itself goes straight to the active set
            if (disp_load) begin
                act_val_d    = disp_value;
                act_dp_d     = disp_dp;
                act_en_d     = disp_en;
                pend_valid_d = 1'b0;
            end else if (pend_valid_q) begin
                act_val_d    = pend_val_q;
                act_dp_d     = pend_dp_q;
                act_en_d     = pend_en_q;
                pend_valid_d = 1'b0;
            end
        end else if (disp_load) begin
            pend_val_d   = disp_value;
            pend_dp_d    = disp_dp;
            pend_en_d    = disp_en;
            pend_valid_d = 1'b1;
        end
    end

    // Leading-zero mask: walk down from digit 3, blanking zero digits until a nonzero enabled one
`ifdef SEG_LEADING_ZERO_BLANK_EN
    always_comb begin
        logic leading;
        lz_blank = 4'b0000;
        leading  = 1'b1;
        for (int i = 3; i >= 1; i--) begin
            if (act_en_q[i]) begin
                if (leading && (act_val_q[4*i +: 4] == 4'h0)) begin
                    lz_blank[i] = 1'b1;
                end else begin
                    leading = 1'b0;
                end
            end
        end
    end
`else
    always_comb begin
        lz_blank = 4'b0000;
    end
`endif

    // Slot phase selection and next pin values, computed active-high then mapped to pin polarity
    always_comb begin
        logic [6:0] seg_on;
        logic       dp_on;
        logic [3:0] an_on;
        seg_on = 7'h00;
        dp_on  = 1'b0;
        an_on  = 4'b0000;
        // cnt+1 <= BLANK_CYC is cnt < BLANK_CYC, written so BLANK_CYC=0 never blanks
        slot_s = ((32'(cnt_q) + 32'd1) <= BLANK_CYC) ? S_BLANK : S_ON;
        case (slot_s)
            S_ON: begin
                if (act_en_q[digit_q]) begin
                    an_on  = 4'b0001 << digit_q;
                    seg_on = hex_decode(nibble);
                    dp_on  = act_dp_q[digit_q];
                    if (lz_blank[digit_q]) begin
                        // A suppressed digit keeps its anode only to show a lit point
                        seg_on = 7'h00;
                        an_on  = act_dp_q[digit_q] ? (4'b0001 << digit_q) : 4'b0000;
                    end
                end
            end
            default: begin
                seg_on = 7'h00;
                dp_on  = 1'b0;
                an_on  = 4'b0000;
            end
        endcase
        seg_d          = seg_on ^ {7{SEG_ACTIVE_LOW}};
        dp_d           = dp_on ^ SEG_ACTIVE_LOW;
        an_d           = an_on ^ {4{AN_ACTIVE_LOW}};
        active_digit_d = digit_q;
        frame_sync_d   = frame_edge_q;
    end

    // State and pin registers; reset blanks the display immediately
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cnt_q          <= '0;
            digit_q        <= 2'd0;
            frame_edge_q   <= 1'b0;
            pend_val_q     <= 16'h0000;
            pend_dp_q      <= 4'h0;
            pend_en_q      <= 4'h0;
            pend_valid_q   <= 1'b0;
            act_val_q      <= 16'h0000;
            act_dp_q       <= 4'h0;
            act_en_q       <= 4'h0;
            seg_q          <= {7{SEG_ACTIVE_LOW}};
            dp_q           <= SEG_ACTIVE_LOW;
            an_q           <= {4{AN_ACTIVE_LOW}};
            active_digit_q <= 2'd0;
            frame_sync_q   <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            digit_q        <= digit_d;
            frame_edge_q   <= frame_edge_d;
            pend_val_q     <= pend_val_d;
            pend_dp_q      <= pend_dp_d;
            pend_en_q      <= pend_en_d;
            pend_valid_q   <= pend_valid_d;
            act_val_q      <= act_val_d;
            act_dp_q       <= act_dp_d;
            act_en_q       <= act_en_d;
            seg_q          <= seg_d;
            dp_q           <= dp_d;
            an_q           <= an_d;
            active_digit_q <= active_digit_d;
            frame_sync_q   <= frame_sync_d;
        end
    end

    assign seg          = seg_q;
    assign dp           = dp_q;
    assign an           = an_q;
    assign active_digit = active_digit_q;
    assign frame_sync   = frame_sync_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb/tb_seven_seg_scan_driver.sv - directed self-checking bench for seven_seg_scan_driver
`timescale 1ns/1ps
module tb_seven_seg_scan_driver;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [15:0] disp_value = 16'h0000;
    logic [3:0]  disp_dp = 4'h0;
    logic [3:0]  disp_en = 4'h0;
    logic        disp_load = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [1:0]  active_digit;
    logic        frame_sync;

    int checks = 0;
    int failures = 0;

    seven_seg_scan_driver #(
        .REFRESH_DIV(8),
        .BLANK_CYC(2),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .ACLK(ACLK),
        .ARESETN(ARESETN),
        .disp_value(disp_value),
        .disp_dp(disp_dp),
        .disp_en(disp_en),
        .disp_load(disp_load),
        .seg(seg),
        .dp(dp),
        .an(an),
        .active_digit(active_digit),
        .frame_sync(frame_sync)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] dec(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[n];
    endfunction

    // Expected {an,seg,dp,active_digit,frame_sync} at pin-cycle k of a frame (k=0 is the frame_sync cycle)
    function automatic logic [14:0] model(input int k, input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
        int         dig;
        int         c;
        logic [3:0] a;
        logic [6:0] s;
        logic       p;
        logic       blank;
        dig = k / 8;
        c   = k % 8;
        a = 4'hF;
        s = 7'h7F;
        p = 1'b1;
        if (c >= 2 && e[dig]) begin
            a = ~(4'b0001 << dig);
            s = ~dec(v[dig*4 +: 4]);
            p = ~d[dig];
`ifdef SEG_LEADING_ZERO_BLANK_EN
            blank = (dig != 0) && (v[dig*4 +: 4] == 4'h0);
            for (int i = 3; i > dig; i--) begin
                if (e[i] && v[i*4 +: 4] != 4'h0) blank = 1'b0;
            end
            if (blank) begin
                s = 7'h7F;
                a = d[dig] ? ~(4'b0001 << dig) : 4'hF;
            end
`else
            blank = 1'b0;
            if (blank) s = 7'h7F;
`endif
        end
        return {a, s, p, 2'(dig), (k == 0)};
    endfunction

    task automatic wait_fs(input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge ACLK);
            if (frame_sync === 1'b1) begin
                ok = 1;
                break;
            end
        end
        check({tag, "_fs_seen"}, 32'(ok), 32'd1);
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
        disp_value = v;
        disp_dp    = d;
        disp_en    = e;
        disp_load  = 1'b1;
        @(negedge ACLK);
        disp_load  = 1'b0;
    endtask

    // Called on a frame_sync negedge; checks 32 cycles and that the next frame_sync is 32 later
    task automatic capture_frame(input string tag, input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
        for (int k = 0; k < 32; k++) begin
            check($sformatf("%s_k%0d", tag, k), 32'({an, seg, dp, active_digit, frame_sync}), 32'(model(k, v, d, e)));
            @(negedge ACLK);
        end
        check({tag, "_period32"}, 32'(frame_sync), 32'd1);
    endtask

    // After release at a negedge: blank display, first frame_sync 33 negedges later
    task automatic check_restart(input string tag);
        int bad;
        int first_fs;
        bad = 0;
        first_fs = -1;
        for (int i = 1; i <= 64; i++) begin
            @(negedge ACLK);
            if (i == 1) check({tag, "_digit0"}, 32'(active_digit), 32'd0);
            if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) bad++;
            if (frame_sync === 1'b1 && first_fs < 0) first_fs = i;
        end
        check({tag, "_blank64"}, 32'(bad), 32'd0);
        check({tag, "_first_fs"}, 32'(first_fs), 32'd33);
    endtask

    initial begin
        bit saw_a;
        // Reset values
        repeat (3) @(negedge ACLK);
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'd1);
        check("rst_fs", 32'(frame_sync), 32'd0);
        check("rst_digit", 32'(active_digit), 32'd0);
        ARESETN = 1'b1;
        check_restart("idle");

        // Basic display of 1234
        wait_fs("pre1234");
        load(16'h1234, 4'h0, 4'hF);
        wait_fs("f1234");
        check("d0_seg4", 32'({an, seg}), 32'({4'hF, 7'h7F}));
        capture_frame("f1234", 16'h1234, 4'h0, 4'hF);

        // Last-wins mid-frame loads: AAAA never shown
        repeat (5) @(negedge ACLK);
        load(16'hAAAA, 4'h0, 4'hF);
        repeat (2) @(negedge ACLK);
        load(16'h5555, 4'h0, 4'hF);
        saw_a = 0;
        for (int i = 0; i < 40; i++) begin
            if (seg === 7'h08) saw_a = 1;
            @(negedge ACLK);
            if (frame_sync === 1'b1) break;
        end
        check("no_a_old_frame", 32'(frame_sync), 32'd1);
        capture_frame("f5555", 16'h5555, 4'h0, 4'hF);
        check("no_a_seen", 32'(saw_a), 32'd0);

        // Partial enable mask with a decimal point on digit 0
        load(16'h5555, 4'b0001, 4'b0101);
        wait_fs("fen");
        capture_frame("fen", 16'h5555, 4'b0001, 4'b0101);

        // Load landing exactly on the frame boundary cycle bypasses pending
        repeat (30) @(negedge ACLK);
        load(16'h00F0, 4'h0, 4'hF);
        wait_fs("fbnd");
        capture_frame("fbnd", 16'h00F0, 4'h0, 4'hF);

        // Asynchronous reset during the digit-2 ON phase
        repeat (20) @(negedge ACLK);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        check("d2_on_before_rst", 32'(an), 32'hF);
`else
        check("d2_on_before_rst", 32'({an, seg}), 32'({4'b1011, 7'h40}));
`endif
        #2 ARESETN = 1'b0;
        #1;
        check("arst_an", 32'(an), 32'hF);
        check("arst_seg", 32'(seg), 32'h7F);
        check("arst_dp", 32'(dp), 32'd1);
        check("arst_fs_digit", 32'({frame_sync, active_digit}), 32'd0);
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        check_restart("post_rst");

`ifdef SEG_LEADING_ZERO_BLANK_EN
        wait_fs("prelz");
        load(16'h0050, 4'b0100, 4'hF);
        wait_fs("flz");
        capture_frame("flz", 16'h0050, 4'b0100, 4'hF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
Downstream consumer of the seven-segment AXI4-Lite register slave. Takes the 16-bit display value, decimal-point bits and digit-enable mask from the slave's registers. Drives a 4-digit common-anode multiplexed display: hex-to-segment decode, time-multiplexed anode scan with anti-ghosting blank interval, and frame-atomic double-buffered update.

Parameters:
REFRESH_DIV, 100000, ACLK cycles per digit slot (1 ms at 100 MHz); must be >= 2
BLANK_CYC, 1000, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV; 0 removes the blank phase
SEG_ACTIVE_LOW, 1, 1 = seg/dp pins active-low
AN_ACTIVE_LOW, 1, 1 = anode pins active-low

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
disp_value  in  16  four hex nibbles; [3:0] = digit0 (rightmost)
disp_dp  in  4  decimal point per digit, 1 = lit
disp_en  in  4  digit enable mask, 1 = digit shown
disp_load  in  1  one-cycle strobe; samples disp_value/disp_dp/disp_en
seg  out  7  segments {g,f,e,d,c,b,a}
dp  out  1  decimal point
an  out  4  anode select, an[i] = digit i
active_digit  out  2  index of the current slot
frame_sync  out  1  one-cycle pulse when the digit-0 slot begins

Behaviour:
- Registers: pending set (value/dp/en plus pending_valid) and active set. Only the active set is displayed.
- disp_load=1: pending <= inputs, pending_valid <= 1. A later load overwrites pending (last wins).
- Slot counter cnt: 0..REFRESH_DIV-1.
- At cnt==REFRESH_DIV-1: cnt <= 0 and digit advances 0->1->2->3->0.
- On wrap 3->0 (frame boundary):
  - frame_sync pulses on the first cycle of the digit-0 slot.
  - If pending_valid, active <= pending and pending_valid <= 0.
  - If disp_load occurs in the boundary cycle, the incoming inputs bypass pending and commit directly to active; pending_valid <= 0.
- Slot FSM, evaluated every cycle:
  - S_BLANK when cnt < BLANK_CYC: all anodes off, seg off, dp off.
  - S_ON otherwise.
  - BLANK_CYC=0 never enters S_BLANK.
- S_ON, digit enabled: an[digit] asserted; seg = decode(nibble); dp = disp_dp[digit].
- S_ON, digit disabled: anodes off, seg/dp off. The slot still consumes REFRESH_DIV cycles, so frame period = 4*REFRESH_DIV always.
- Decode table, active-high {g..a}:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
  - Inverted at pins when SEG_ACTIVE_LOW=1.
- seg/dp/an/active_digit/frame_sync are registered: pins reflect cnt/digit state one cycle later. active_digit is the digit shown on the pins in that same cycle.
- Reset, asynchronous, outputs immediate:
  - an = all off (4'hF when AN_ACTIVE_LOW), seg = off (7'h7F when SEG_ACTIVE_LOW), dp off, active_digit=0, frame_sync=0.
  - cnt=0, digit=0, active and pending sets = 0, pending_valid=0. Display stays blank until the first load commits.
- Reset mid-slot: outputs go to reset values at once. After release, scanning restarts at digit 0, cnt 0, with no frame_sync for this first frame. Loads are accepted from the first cycle after release.

Optional Feature:
SEG_LEADING_ZERO_BLANK_EN
- Defined: starting at digit 3 and moving down, each enabled digit whose nibble is 0 has segments forced off until the first nonzero enabled digit. Digit 0 is never blanked. dp and the anode still follow disp_dp[i], so a blanked digit with its dp set shows only the point.
- Undefined: all enabled digits are decoded literally.

Test Plan (REFRESH_DIV=8, BLANK_CYC=2, active-low pins):
- Hold ARESETN=0 -> an=4'hF, seg=7'h7F, dp=1, frame_sync=0. After release with no load: an stays 4'hF for 64 cycles.
- Load 16'h1234, en=4'hF, dp=4'h0 -> from next frame_sync:
  - digit0: an=4'hF for 2 cycles, then 4'b1110 for 6 cycles, seg=7'h19 (decode of 4).
  - digit3: an=4'b0111, seg=7'h79 (decode of 1).
  - frame period = 32 cycles.
- Mid-frame load 16'hAAAA, then 16'h5555 three cycles later -> no A digit ever appears; 5 (seg=7'h12) on all digits from the next frame_sync.
- disp_en=4'b0101, dp=4'b0001 -> an[1] and an[3] never asserted; dp=0 only in the digit-0 ON phase; frame_sync spacing still 32.
- Assert disp_load with 16'h00F0 in the boundary cycle -> the frame that starts now shows digit1=F (seg=7'h0E). Async reset during the digit-2 ON phase -> outputs off in the same timestep, and scan restarts at digit 0.
- SEG_LEADING_ZERO_BLANK_EN, value 16'h0050, en=4'hF, dp=4'b0100:
  - digit3: seg 7'h7F, an not asserted.
  - digit2: seg 7'h7F with dp lit, an asserted.
  - digit1 = 5, digit0 = 0 (seg=7'h40).
